alu_sort_sequencer: RTL and testbench

//  Hardware selection-sort engine. Initiator side of the ALU compare interface.

---
 rtl/alu_sort_pkg.sv | 16 +
 rtl/sort_regfile.sv | 51 +++++
 rtl/alu_sort_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_sort_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sort_pkg.sv
// Shared types and ALU encodings for the sort sequencer.
// Used by alu_sort_sequencer and sort_regfile.
package alu_sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    SWAP,
    DRAIN
  } state_e;

  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  localparam logic [2:0] ALU_F3_LT  = 3'b100;
  localparam logic [2:0] ALU_F3_EQ  = 3'b000;

endpackage

// File: rtl/sort_regfile.sv
// Element buffer for the sort sequencer: one write port,
// two combinational read ports and a same-cycle swap port.
module sort_regfile #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_en,
  input  logic [IDX_W-1:0]  swap_a,
  input  logic [IDX_W-1:0]  swap_b,
  input  logic [IDX_W-1:0]  ra_idx,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign ra_data = mem_q[ra_idx];
  assign rb_data = mem_q[rb_idx];

  // next array contents: load write or exchange of two slots
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
    if (swap_en) begin
      mem_d[swap_a] = mem_q[swap_b];
      mem_d[swap_b] = mem_q[swap_a];
    end
  end

  // storage, cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_sort_sequencer.sv
// Selection-sort engine driving an external compare ALU.
// Define SORT_DESCENDING_EN for non-increasing output order.
module alu_sort_sequencer
  import alu_sort_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_operation,
  output logic [2:0]        alu_func3,
  input  logic              alu_zero,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  state_e state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] min_q, min_d;
  logic [IDX_W-1:0] rd_q, rd_d;

  logic              wr_en;
  logic              swap_en;
  logic [IDX_W-1:0]  ra_idx;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;

  logic [CNT_W-1:0] n_m1;
  logic [CNT_W-1:0] n_m2;
  logic             j_end;
  logic             i_end;
  logic             rd_end;
  logic             load_end;

  assign n_m1     = n_q - CNT_W'(1);
  assign n_m2     = n_q - CNT_W'(2);
  assign j_end    = {1'b0, j_q} == n_m1;
  assign i_end    = {1'b0, i_q} == n_m2;
  assign rd_end   = {1'b0, rd_q} == n_m1;
  assign load_end = in_last || (n_q == CNT_W'(DEPTH - 1));

  assign ra_idx = (state_q == DRAIN) ? rd_q : j_q;

  sort_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_idx  (n_q[IDX_W-1:0]),
    .wr_data (in_data),
    .swap_en (swap_en),
    .swap_a  (i_q),
    .swap_b  (min_q),
    .ra_idx  (ra_idx),
    .ra_data (ra_data),
    .rb_idx  (min_q),
    .rb_data (rb_data)
  );

  assign in_ready      = state_q == LOAD;
  assign out_valid     = state_q == DRAIN;
  assign busy          = state_q != LOAD;
  assign out_data      = out_valid ? ra_data : '0;
  assign out_last      = out_valid && rd_end;
  assign alu_operation = ALU_OP_SUB;
  assign alu_func3     = ALU_F3_LT;

  // next state, counters and ALU operands
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    min_d   = min_q;
    rd_d    = rd_q;
    wr_en   = 1'b0;
    swap_en = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          n_d   = n_q + CNT_W'(1);
          if (load_end) begin
            if (n_q == '0) begin
              state_d = DRAIN;
              rd_d    = '0;
            end else begin
              state_d = SCAN;
              i_d     = '0;
              min_d   = '0;
              j_d     = IDX_W'(1);
            end
          end
        end
      end
      SCAN: begin
`ifdef SORT_DESCENDING_EN
        alu_a = rb_data;
        alu_b = ra_data;
`else
        alu_a = ra_data;
        alu_b = rb_data;
`endif
        if (alu_zero) begin
          min_d = j_q;
        end
        j_d = j_q + IDX_W'(1);
        if (j_end) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        swap_en = 1'b1;
        if (i_end) begin
          state_d = DRAIN;
          rd_d    = '0;
        end else begin
          state_d = SCAN;
          i_d     = i_q + IDX_W'(1);
          min_d   = i_q + IDX_W'(1);
          j_d     = i_q + IDX_W'(2);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_end) begin
            state_d = LOAD;
            n_d     = '0;
          end else begin
            rd_d = rd_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      min_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      min_q   <= min_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_alu_sort_sequencer.sv
// Directed bench for alu_sort_sequencer with a behavioural compare ALU.
// Honours SORT_DESCENDING_EN by reversing expected order.
module tb_alu_sort_sequencer;

`ifdef SORT_DESCENDING_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_operation;
  logic [2:0]  alu_func3;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [63:0] vals [8];
  logic [63:0] expv [8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign alu_zero = (alu_operation === 4'b0110 && alu_func3 === 3'b100)
                  ? (alu_a < alu_b) : 1'b0;

  alu_sort_sequencer #(
    .DEPTH  (8),
    .DATA_W (64)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_operation (alu_operation),
    .alu_func3     (alu_func3),
    .alu_zero      (alu_zero),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
    chk({tag, "_alu_b"}, alu_b, 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
  endtask

  // drive vals[0..cnt-1]; returns at the negedge after the last accept
  task automatic send(input int cnt, input bit with_last);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vals[k];
      in_last  = with_last && (k == cnt - 1);
      chk("load_in_ready", 64'(in_ready), 64'd1);
      if (k == 0) t0 = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chk("post_load_in_ready", 64'(in_ready), 64'd0);
    chk("post_load_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_first(input int exp_lat);
    int g;
    g = 0;
    while (out_valid !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("latency", 64'(cyc - t0), 64'(exp_lat));
  endtask

  // drain cnt words against expv (ascending), optional 1/0 backpressure
  task automatic drain(input int cnt, input bit toggle);
    int k;
    int g;
    bit tog;
    logic [63:0] e;
    k   = 0;
    g   = 0;
    tog = 1'b1;
    while (k < cnt && g < 100) begin
      out_ready = toggle ? tog : 1'b1;
      tog = ~tog;
      e = DESC ? expv[cnt-1-k] : expv[k];
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_data", out_data, e);
      chk("out_last", 64'(out_last), 64'(k == cnt - 1));
      chk("drain_in_ready", 64'(in_ready), 64'd0);
      if (out_ready) k++;
      g++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_done", 64'(k), 64'(cnt));
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("alu_operation", 64'(alu_operation), 64'h6);
    chk("alu_func3", 64'(alu_func3), 64'h4);
    reset_n = 1'b1;

    // 1: basic ascending sort, first SCAN operands and latency
    vals[0] = 64'd5; vals[1] = 64'd3; vals[2] = 64'd9; vals[3] = 64'd1;
    expv[0] = 64'd1; expv[1] = 64'd3; expv[2] = 64'd5; expv[3] = 64'd9;
    send(4, 1'b1);
    chk("t1_alu_a", alu_a, DESC ? 64'd5 : 64'd3);
    chk("t1_alu_b", alu_b, DESC ? 64'd3 : 64'd5);
    wait_first(13);
    drain(4, 1'b0);

    // 2: full batch, implicit last after the eighth word
    for (int k = 0; k < 8; k++) begin
      vals[k] = 64'(8 - k);
      expv[k] = 64'(k + 1);
    end
    send(8, 1'b0);
    wait_first(43);
    drain(8, 1'b0);

    // 3: single element skips sorting
    vals[0] = 64'd42;
    expv[0] = 64'd42;
    send(1, 1'b1);
    wait_first(1);
    drain(1, 1'b0);

    // 4: duplicates with alternating backpressure
    vals[0] = 64'd7; vals[1] = 64'd7; vals[2] = 64'd2; vals[3] = 64'd7;
    expv[0] = 64'd2; expv[1] = 64'd7; expv[2] = 64'd7; expv[3] = 64'd7;
    send(4, 1'b1);
    wait_first(13);
    drain(4, 1'b1);

    // 5: unsigned extreme values
    vals[0] = 64'hFFFF_FFFF_FFFF_FFFF; vals[1] = 64'd1;
    expv[0] = 64'd1; expv[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    send(2, 1'b1);
    wait_first(4);
    drain(2, 1'b0);

    // 6: reset in the middle of SCAN, then a clean batch
    vals[0] = 64'd6; vals[1] = 64'd5; vals[2] = 64'd4;
    send(3, 1'b1);
    chk("t6_busy_scan", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    chk_reset_outputs("midreset_hold");
    reset_n = 1'b1;
    vals[0] = 64'd2; vals[1] = 64'd1;
    expv[0] = 64'd1; expv[1] = 64'd2;
    send(2, 1'b1);
    wait_first(4);
    drain(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
